// File: rtl/cps2_raster_pkg.sv
// Shared definitions for the CPS-2 raster interrupt generator: counter width,
// register select bit positions and the read-back priority encoder.
package cps2_raster_pkg;

  localparam int CW = 9;

  localparam int SEL_R1   = 0;
  localparam int SEL_R2   = 1;
  localparam int SEL_HCMP = 2;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_R1   = 2'd1,
    RD_R2   = 2'd2,
    RD_HCMP = 2'd3
  } rd_src_t;

  // When several select bits are set, raster1 wins, then raster2, then hcmp.
  function automatic rd_src_t read_pick(input logic [2:0] sel);
    if (sel[SEL_R1])
      return RD_R1;
    else if (sel[SEL_R2])
      return RD_R2;
    else if (sel[SEL_HCMP])
      return RD_HCMP;
    else
      return RD_NONE;
  endfunction

endpackage

// File: rtl/cps2_line_cnt.sv
// One raster line counter: preset register, live down-counter and pending flag.
// Optional feature macro: CPS2_RASTER_RELOAD_EN (reload from preset on expiry,
// giving a periodic interrupt every preset lines within a frame).
module cps2_line_cnt
  import cps2_raster_pkg::*;
#(
  parameter int CW = cps2_raster_pkg::CW
)(
  input  logic          clk,
  input  logic          reg_rst,
  input  logic          load,
  input  logic [CW-1:0] din,
  input  logic          frame_start,
  input  logic          line_inc,
  input  logic          clr_pend,
  output logic [CW-1:0] cnt,
  output logic          pend
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] preset;

  // CPU load beats frame_start, which beats line counting; a zero preset
  // never counts, so it can never arm. A flag armed on this edge survives a
  // clear from a firing on the same edge, since that firing saw the old flag.
  always_ff @(posedge clk or posedge reg_rst) begin
    if (reg_rst) begin
      preset <= '0;
      cnt    <= '0;
      pend   <= 1'b0;
    end else if (load) begin
      preset <= din;
      cnt    <= din;
      pend   <= 1'b0;
    end else if (frame_start) begin
      cnt  <= preset;
      pend <= 1'b0;
    end else begin
      if (clr_pend)
        pend <= 1'b0;
      if (line_inc && (preset != '0) && (cnt != '0)) begin
        if (cnt == ONE) begin
          pend <= 1'b1;
`ifdef CPS2_RASTER_RELOAD_EN
          cnt  <= preset;
`else
          cnt  <= '0;
`endif
        end else begin
          cnt <= cnt - ONE;
        end
      end
    end
  end

endmodule

// File: rtl/cps2_raster.sv
// CPS-2 raster interrupt generator: two line counters arm an interrupt that
// fires when the pixel counter reaches the programmed horizontal position.
// Optional feature macro: CPS2_RASTER_RELOAD_EN (periodic line counters).
module cps2_raster
  import cps2_raster_pkg::*;
#(
  parameter int CW = cps2_raster_pkg::CW
)(
  input  logic          clk,
  input  logic          reg_rst,
  input  logic          pxl_cen,
  input  logic          frame_start,
  input  logic          line_inc,
  input  logic [2:0]    cnt_sel,
  input  logic          wrn,
  input  logic [15:0]   cpu_dout,
  output logic [CW-1:0] cnt_dout,
  output logic          raster
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] wr_data;
  logic          load1;
  logic          load2;
  logic          load_hcmp;
  logic [CW-1:0] cnt1;
  logic [CW-1:0] cnt2;
  logic          pend1;
  logic          pend2;
  logic [CW-1:0] hcmp;
  logic [CW-1:0] hcnt;
  logic          unused_cpu_bits;

  assign wr_data         = cpu_dout[CW-1:0];
  assign unused_cpu_bits = ^cpu_dout[15:CW];
  assign load1           = !wrn && cnt_sel[SEL_R1];
  assign load2           = !wrn && cnt_sel[SEL_R2];
  assign load_hcmp       = !wrn && cnt_sel[SEL_HCMP];

  cps2_line_cnt #(.CW(CW)) u_raster1 (
    .clk         (clk),
    .reg_rst     (reg_rst),
    .load        (load1),
    .din         (wr_data),
    .frame_start (frame_start),
    .line_inc    (line_inc),
    .clr_pend    (raster),
    .cnt         (cnt1),
    .pend        (pend1)
  );

  cps2_line_cnt #(.CW(CW)) u_raster2 (
    .clk         (clk),
    .reg_rst     (reg_rst),
    .load        (load2),
    .din         (wr_data),
    .frame_start (frame_start),
    .line_inc    (line_inc),
    .clr_pend    (raster),
    .cnt         (cnt2),
    .pend        (pend2)
  );

  // Horizontal compare register, written by the CPU only.
  always_ff @(posedge clk or posedge reg_rst) begin
    if (reg_rst)
      hcmp <= '0;
    else if (load_hcmp)
      hcmp <= wr_data;
  end

  // Pixel position within the line; holds at all-ones so it never wraps.
  always_ff @(posedge clk or posedge reg_rst) begin
    if (reg_rst)
      hcnt <= '0;
    else if (line_inc)
      hcnt <= '0;
    else if (pxl_cen && (hcnt != '1))
      hcnt <= hcnt + ONE;
  end

  // Fire on the matching pixel while any counter is armed; the pulse itself
  // clears the armed flags, so it lasts a single clock.
  always_comb begin
    raster = pxl_cen && (hcnt == hcmp) && (pend1 || pend2);
  end

  // CPU read-back of the selected register.
  always_comb begin
    cnt_dout = '0;
    case (read_pick(cnt_sel))
      RD_R1:   cnt_dout = cnt1;
      RD_R2:   cnt_dout = cnt2;
      RD_HCMP: cnt_dout = hcmp;
      default: cnt_dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cps2_raster.sv
// Self-checking bench for cps2_raster. Expected raster pulses (frame, line,
// pixel) are queued as each line is driven and matched against observed ones.
// Honours CPS2_RASTER_RELOAD_EN when computing expected pulse lines.
module tb_cps2_raster;
  import cps2_raster_pkg::*;

  localparam int PIX  = 16;
  localparam int HCMP = 10;

  logic          clk = 1'b0;
  logic          reg_rst;
  logic          pxl_cen;
  logic          frame_start;
  logic          line_inc;
  logic [2:0]    cnt_sel;
  logic          wrn;
  logic [15:0]   cpu_dout;
  logic [CW-1:0] cnt_dout;
  logic          raster;

  int n_pass  = 0;
  int n_total = 0;

  int cur_frame = 0;
  int cur_line  = 0;
  int cur_pix   = 0;

  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  cps2_raster #(.CW(CW)) dut (
    .clk         (clk),
    .reg_rst     (reg_rst),
    .pxl_cen     (pxl_cen),
    .frame_start (frame_start),
    .line_inc    (line_inc),
    .cnt_sel     (cnt_sel),
    .wrn         (wrn),
    .cpu_dout    (cpu_dout),
    .cnt_dout    (cnt_dout),
    .raster      (raster)
  );

  function automatic logic [31:0] tag(input int f, input int l, input int p);
    logic [31:0] t;
    t = {f[11:0], l[9:0], p[9:0]};
    return t;
  endfunction

  // Lines (counted from the last load) on which a counter should fire.
  function automatic bit fires(input int p, input int start, input int l);
    int d;
    d = l - start;
    if (p == 0 || d <= 0)
      return 1'b0;
`ifdef CPS2_RASTER_RELOAD_EN
    return (d % p) == 0;
`else
    return d == p;
`endif
  endfunction

  // Scoreboard side: every observed pulse must match the oldest expected one.
  always @(negedge clk) begin
    logic [31:0] got;
    logic [31:0] want;
    if (raster === 1'b1) begin
      got = tag(cur_frame, cur_line, pxl_cen ? cur_pix : 1023);
      n_total++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL pulse_unexpected: got frame %0d line %0d pix %0d, required no pulse",
                 got[31:20], got[19:10], got[9:0]);
      end else begin
        want = exp_q.pop_front();
        if (got !== want)
          $display("[TB] FAIL pulse_position: got f%0d/l%0d/p%0d, required f%0d/l%0d/p%0d",
                   got[31:20], got[19:10], got[9:0], want[31:20], want[19:10], want[9:0]);
        else
          n_pass++;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reg_rst     = 1'b1;
    pxl_cen     = 1'b0;
    frame_start = 1'b0;
    line_inc    = 1'b0;
    cnt_sel     = 3'b000;
    wrn         = 1'b1;
    cpu_dout    = 16'h0000;
    repeat (3) step;
    reg_rst = 1'b0;
    step;
  endtask

  // Write held for two clocks; repeating a write must be harmless.
  task automatic cpu_write(input logic [2:0] sel, input logic [15:0] d);
    cnt_sel  = sel;
    cpu_dout = d;
    wrn      = 1'b0;
    step;
    step;
    wrn      = 1'b1;
    cnt_sel  = 3'b000;
    cpu_dout = 16'h0000;
  endtask

  task automatic read_reg(input logic [2:0] sel, output logic [CW-1:0] v);
    cnt_sel = sel;
    #1;
    v = cnt_dout;
  endtask

  task automatic start_frame;
    step;
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
    cur_frame++;
    cur_line = 0;
  endtask

  // Drives one video line; exp_pix < 0 means no pulse is expected on it.
  task automatic applyStimulus(input int l, input int npix, input int exp_pix);
    if (exp_pix >= 0)
      exp_q.push_back(tag(cur_frame, l, exp_pix));
    line_inc = 1'b1;
    cur_line = l;
    cur_pix  = 0;
    step;
    line_inc = 1'b0;
    step;
    for (int j = 0; j < npix; j++) begin
      pxl_cen = 1'b1;
      cur_pix = j;
      step;
      pxl_cen = 1'b0;
      step;
    end
  endtask

  task automatic test_reset;
    logic [CW-1:0] v;
    do_reset;
    read_reg(3'b000, v);
    n_total++;
    if (v !== '0) $display("[TB] FAIL rst_rd_none: got %h required 0", v); else n_pass++;
    read_reg(3'b001, v);
    n_total++;
    if (v !== '0) $display("[TB] FAIL rst_rd_cnt1: got %h required 0", v); else n_pass++;
    n_total++;
    if (raster !== 1'b0) $display("[TB] FAIL rst_raster: got %b required 0", raster); else n_pass++;
    for (int f = 0; f < 3; f++) begin
      start_frame;
      for (int l = 1; l <= 4; l++)
        applyStimulus(l, PIX, -1);
      n_total++;
      if (exp_q.size() != 0) begin
        $display("[TB] FAIL rst_frame_pulses: got %0d missing, required 0", exp_q.size());
        exp_q.delete();
      end else n_pass++;
    end
  endtask

  task automatic test_program_readback;
    logic [CW-1:0] v;
    cpu_write(3'b001, 16'h0105);
    cpu_write(3'b100, 16'h0030);
    cpu_write(3'b010, 16'hFE07);
    read_reg(3'b001, v);
    n_total++;
    if (v !== 9'h105) $display("[TB] FAIL rd_cnt1: got %h required 105", v); else n_pass++;
    read_reg(3'b100, v);
    n_total++;
    if (v !== 9'h030) $display("[TB] FAIL rd_hcmp: got %h required 030", v); else n_pass++;
    read_reg(3'b010, v);
    n_total++;
    if (v !== 9'h007) $display("[TB] FAIL rd_cnt2_masked: got %h required 007", v); else n_pass++;
    read_reg(3'b111, v);
    n_total++;
    if (v !== 9'h105) $display("[TB] FAIL rd_prio_r1: got %h required 105", v); else n_pass++;
    read_reg(3'b110, v);
    n_total++;
    if (v !== 9'h007) $display("[TB] FAIL rd_prio_r2: got %h required 007", v); else n_pass++;
    cnt_sel = 3'b000;
  endtask

  task automatic test_line_irq;
    cpu_write(3'b001, 16'd3);
    cpu_write(3'b010, 16'd0);
    cpu_write(3'b100, 16'(HCMP));
    for (int f = 0; f < 2; f++) begin
      start_frame;
      for (int l = 1; l <= 6; l++)
        applyStimulus(l, PIX, fires(3, 0, l) ? HCMP : -1);
      n_total++;
      if (exp_q.size() != 0) begin
        $display("[TB] FAIL line_irq_missing: got %0d unseen, required 0", exp_q.size());
        exp_q.delete();
      end else n_pass++;
    end
  endtask

  task automatic test_both_counters;
    logic [CW-1:0] v;
    cpu_write(3'b001, 16'd2);
    cpu_write(3'b010, 16'd5);
    start_frame;
    for (int l = 1; l <= 6; l++) begin
      applyStimulus(l, PIX, (fires(2, 0, l) || fires(5, 0, l)) ? HCMP : -1);
      if (l == 3) begin
        read_reg(3'b010, v);
        n_total++;
        if (v !== 9'd2) $display("[TB] FAIL both_cnt2_line3: got %0d required 2", v); else n_pass++;
        cnt_sel = 3'b000;
      end
    end
    n_total++;
    if (exp_q.size() != 0) begin
      $display("[TB] FAIL both_missing: got %0d unseen, required 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  task automatic test_disable;
    cpu_write(3'b001, 16'd0);
    cpu_write(3'b010, 16'd0);
    for (int f = 0; f < 2; f++) begin
      start_frame;
      for (int l = 1; l <= 6; l++)
        applyStimulus(l, PIX, -1);
      n_total++;
      if (exp_q.size() != 0) begin
        $display("[TB] FAIL disable_missing: got %0d unseen, required 0", exp_q.size());
        exp_q.delete();
      end else n_pass++;
    end
    start_frame;
    for (int l = 1; l <= 8; l++) begin
      applyStimulus(l, PIX, fires(4, 2, l) ? HCMP : -1);
      if (l == 2)
        cpu_write(3'b001, 16'd4);
    end
    n_total++;
    if (exp_q.size() != 0) begin
      $display("[TB] FAIL midframe_missing: got %0d unseen, required 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  task automatic test_reload;
    cpu_write(3'b001, 16'd4);
    cpu_write(3'b010, 16'd0);
    start_frame;
    for (int l = 1; l <= 13; l++)
      applyStimulus(l, PIX, fires(4, 0, l) ? HCMP : -1);
    n_total++;
    if (exp_q.size() != 0) begin
      $display("[TB] FAIL reload_missing: got %0d unseen, required 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  task automatic test_hpos_bounds;
    cpu_write(3'b001, 16'd1);
    cpu_write(3'b010, 16'd0);
    cpu_write(3'b100, 16'd0);
    start_frame;
    applyStimulus(1, 4, 0);
    cpu_write(3'b100, 16'h01FF);
    start_frame;
    for (int l = 1; l <= 2; l++)
      applyStimulus(l, 520, fires(1, 0, l) ? 511 : -1);
    n_total++;
    if (exp_q.size() != 0) begin
      $display("[TB] FAIL hpos_missing: got %0d unseen, required 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  initial begin
    reg_rst     = 1'b1;
    pxl_cen     = 1'b0;
    frame_start = 1'b0;
    line_inc    = 1'b0;
    cnt_sel     = 3'b000;
    wrn         = 1'b1;
    cpu_dout    = 16'h0000;
    test_reset;
    test_program_readback;
    test_line_irq;
    test_both_counters;
    test_disable;
    test_reload;
    test_hpos_bounds;
    repeat (4) step;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
